// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver
//   Write-only HD44780 bus driver. After reset it waits T_PWRUP cycles and then
//   sends the six-byte init sequence (0x38 x3, 0x0C, 0x01, 0x06). After that it
//   accepts one command/data byte at a time from the controller stage and
//   produces the setup / enable-pulse / hold / execution-wait timing on the pins.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        write request (accepted only when ready=1)
//   rs_in      0 = command, 1 = character data
//   data_in    byte to write
//   ready      driver idle and able to accept a write
//   init_done  power-on init sequence has completed (sticky until reset)
//   lcd_rs, lcd_rw, lcd_en, lcd_data   HD44780 pins (lcd_rw tied low)
module lcd_bus_driver #(
  parameter int unsigned T_PWRUP     = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN        = 25,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One shared down-counter, wide enough for the longest interval.
  localparam int unsigned CNT_MAX = max2(max2(max2(T_PWRUP, T_EXEC_LONG), max2(T_EXEC, T_EN)),
                                         max2(T_SETUP, T_HOLD));
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LD_PWRUP = cnt_t'(T_PWRUP);
  localparam cnt_t LD_SETUP = cnt_t'(T_SETUP - 1);
  localparam cnt_t LD_EN    = cnt_t'(T_EN - 1);
  localparam cnt_t LD_HOLD  = cnt_t'(T_HOLD - 1);
  localparam cnt_t LD_EXEC  = cnt_t'(T_EXEC - 1);
  localparam cnt_t LD_LONG  = cnt_t'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE
  } state_t;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;  // function set: 8-bit, 2 lines, 5x8
      3'd3:             return 8'h0C;  // display on, cursor off
      3'd4:             return 8'h01;  // clear display
      default:          return 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  state_t     state_q;
  cnt_t       cnt_q;
  logic [2:0] idx_q;
  logic       ready_q;
  logic       init_done_q;
  logic       lcd_rs_q;
  logic       lcd_en_q;
  logic [7:0] lcd_data_q;
  logic       long_exec;

  // Clear display / return home need the long execution wait; decided from the
  // byte actually on the bus so init steps and user writes share the rule.
  assign long_exec = !lcd_rs_q && (lcd_data_q inside {8'h01, 8'h02, 8'h03});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= LD_PWRUP;
      idx_q       <= 3'd0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
    end else begin
      case (state_q)
        S_PWRUP: begin
          if (cnt_q <= cnt_t'(1)) state_q <= S_LOAD;
          else                    cnt_q   <= cnt_q - cnt_t'(1);
        end
        // Init steps enter here; this edge plays the role of the acceptance edge.
        S_LOAD: begin
          lcd_rs_q   <= 1'b0;
          lcd_data_q <= init_rom(idx_q);
          cnt_q      <= LD_SETUP;
          state_q    <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            lcd_en_q <= 1'b1;
            cnt_q    <= LD_EN;
            state_q  <= S_PULSE;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            lcd_en_q <= 1'b0;
            cnt_q    <= LD_HOLD;
            state_q  <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cnt_q   <= long_exec ? LD_LONG : LD_EXEC;
            state_q <= S_EXEC;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            if (init_done_q || idx_q == 3'd5) begin
              init_done_q <= 1'b1;
              ready_q     <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= S_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_IDLE: begin
          if (req) begin
            lcd_rs_q   <= rs_in;
            lcd_data_q <= data_in;
            ready_q    <= 1'b0;
            cnt_q      <= LD_SETUP;
            state_q    <= S_SETUP;
          end
        end
        default: begin
          ready_q  <= 1'b0;
          lcd_en_q <= 1'b0;
          state_q  <= S_PWRUP;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = lcd_en_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: doc/lcd_bus_driver.md
LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 SHALL have parameter T_PWRUP, default 750000, power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter T_SETUP, default 2, cycles lcd_rs/lcd_data are stable before lcd_en rises.
REQ-003 SHALL have parameter T_EN, default 25, cycles lcd_en is held high.
REQ-004 SHALL have parameter T_HOLD, default 2, cycles lcd_rs/lcd_data are held after lcd_en falls.
REQ-005 SHALL have parameter T_EXEC, default 2000, command/data execution wait in cycles (40 us).
REQ-006 SHALL have parameter T_EXEC_LONG, default 82000, clear/home execution wait in cycles (1.64 ms).
REQ-007 SHALL have port clk, input, 1, single system clock; all flops are rising-edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req, input, 1, write request from the LCD controller stage.
REQ-010 SHALL have port rs_in, input, 1, 0 = command, 1 = character data.
REQ-011 SHALL have port data_in, input, 8, byte to write.
REQ-012 SHALL have port ready, output, 1, driver idle and able to accept a write.
REQ-013 SHALL have port init_done, output, 1, power-on init sequence has completed.
REQ-014 SHALL have ports lcd_rs, lcd_rw, lcd_en (output, 1 each) and lcd_data (output, 8), the HD44780 pins.

Function
REQ-015 SHALL implement states PWRUP, LOAD, SETUP, PULSE, HOLD, EXEC, IDLE with one shared down-counter sized for the largest parameter.
REQ-016 SHALL stay in PWRUP for T_PWRUP cycles after reset release, then run the init ROM: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with rs=0.
REQ-017 SHALL run each init byte through SETUP, PULSE, HOLD, EXEC exactly as a user write, using the exec-time rule of REQ-022.
REQ-018 SHALL set init_done=1 and ready=1 on the same edge EXEC of the 6th init byte ends; init_done SHALL then stay 1 until reset.
REQ-019 SHALL assert ready only in IDLE; a write is accepted on a rising edge where ready=1 and req=1, capturing rs_in and data_in.
REQ-020 SHALL ignore req while ready=0 (no queueing); held req after completion is accepted again as a new write.
REQ-021 On acceptance at edge k: ready=0 and lcd_rs/lcd_data take the captured values from edge k; lcd_en=1 from edge k+T_SETUP to edge k+T_SETUP+T_EN; ready=1 again at edge k+T_SETUP+T_EN+T_HOLD+Texec.
REQ-022 SHALL use Texec = T_EXEC_LONG when rs=0 and data in {0x01, 0x02, 0x03}; otherwise Texec = T_EXEC.
REQ-023 SHALL hold lcd_rs/lcd_data constant from SETUP entry through end of HOLD; lcd_en SHALL be high only in PULSE.
REQ-024 SHALL drive lcd_rw=0 at all times (write-only; no busy-flag read).
REQ-025 SHALL keep lcd_data/lcd_rs at the last written values while in EXEC and IDLE.
REQ-026 SHALL ignore data_in/rs_in changes after acceptance until the write completes.

Reset
REQ-027 SHALL, while rst_n=0, force ready=0, init_done=0, lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_data=0x00, state=PWRUP, counter=T_PWRUP, ROM index=0.
REQ-028 SHALL abort any in-progress write or init step on reset assertion (lcd_en drops immediately) and restart the full power-up sequence after release.

Verification (T_PWRUP=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=40)
REQ-029 Bench SHALL check init: release rst_n -> exactly 6 lcd_en pulses of 4 cycles with lcd_data 0x38,0x38,0x38,0x0C,0x01,0x06, lcd_rs=0; gap after 0x01 is 40 cycles; init_done=ready=1 after the 6th exec.
REQ-030 Bench SHALL check a data write: req=1, rs_in=1, data_in=0x41 at edge k -> lcd_rs=1, lcd_data=0x41 at k, lcd_en high k+2..k+6, ready=1 at k+18.
REQ-031 Bench SHALL check long exec: command 0x01 -> ready returns at k+48; command 0x80 -> ready returns at k+18.
REQ-032 Bench SHALL check busy rejection: req pulses with 0x55 during a 0x41 write -> only one lcd_en pulse, lcd_data never 0x55.
REQ-033 Bench SHALL check mid-pulse reset: rst_n=0 while lcd_en=1 -> lcd_en=0, ready=0, init_done=0 immediately; after release, the init sequence of REQ-029 repeats in full.
REQ-034 Bench SHALL check back-to-back: req held high with data changing each write -> each write captured at its ready edge, lcd_rw=0 throughout.
